// File: rtl/ru_write_arbiter.sv
// Register-unit write-port arbiter: two one-entry holding buffers, fixed
// priority to source 0 with a starvation limit for source 1, registered
// write port and a pending-write mask for RAW hazard stalls.
module ru_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [4:0]  RUrd,
  output logic [31:0] RUDatawr,
  output logic        RUWr,
  output logic [31:0] pending
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NSRC   = 2;

  logic [NSRC-1:0]   r_hold_valid;
  logic [RD_W-1:0]   r_hold_rd   [NSRC];
  logic [DATA_W-1:0] r_hold_data [NSRC];
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_ru_wr;
  logic [RD_W-1:0]   r_ru_rd;
  logic [DATA_W-1:0] r_ru_data;

  logic [NSRC-1:0]   w_valid;
  logic [NSRC-1:0]   w_grant;
  logic [NSRC-1:0]   w_ready;
  logic [NSRC-1:0]   w_accept;
  logic [RD_W-1:0]   w_in_rd   [NSRC];
  logic [DATA_W-1:0] w_in_data [NSRC];
  logic [NREG-1:0]   w_pending;
  logic              w_starved;

  // Grant, ready and accept decode from the held state; x0 writes are dropped.
  always_comb begin
    w_valid      = {req1_valid, req0_valid};
    w_in_rd[0]   = req0_rd;
    w_in_rd[1]   = req1_rd;
    w_in_data[0] = req0_data;
    w_in_data[1] = req1_data;
    w_starved    = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
    w_grant      = '0;
    w_grant[1]   = r_hold_valid[1] && (!r_hold_valid[0] || w_starved);
    w_grant[0]   = r_hold_valid[0] && !w_grant[1];
    w_ready      = ~r_hold_valid | w_grant;
    w_accept     = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      w_accept[i] = w_valid[i] && w_ready[i] && (w_in_rd[i] != '0);
    end
  end

  // Holding buffers: a new accept replaces a granted entry in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_hold_valid <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        r_hold_rd[i]   <= '0;
        r_hold_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NSRC); i++) begin
        if (w_accept[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold_rd[i]    <= w_in_rd[i];
          r_hold_data[i]  <= w_in_data[i];
        end else if (w_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Count consecutive losses of a held source-1 entry; saturate at the limit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_starve_cnt <= '0;
    end else if (!r_hold_valid[1] || w_grant[1]) begin
      r_starve_cnt <= '0;
    end else if (w_grant[0] && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  // Registered write port; address/data keep their last value when idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ru_wr   <= 1'b0;
      r_ru_rd   <= '0;
      r_ru_data <= '0;
    end else if (w_grant[1]) begin
      r_ru_wr   <= 1'b1;
      r_ru_rd   <= r_hold_rd[1];
      r_ru_data <= r_hold_data[1];
    end else if (w_grant[0]) begin
      r_ru_wr   <= 1'b1;
      r_ru_rd   <= r_hold_rd[0];
      r_ru_data <= r_hold_data[0];
    end else begin
      r_ru_wr   <= 1'b0;
    end
  end

  // Pending mask covers both holding buffers and the write on the port.
  always_comb begin
    w_pending = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      w_pending[r] = (r_hold_valid[0] && (r_hold_rd[0] == RD_W'(r))) ||
                     (r_hold_valid[1] && (r_hold_rd[1] == RD_W'(r))) ||
                     (r_ru_wr && (r_ru_rd == RD_W'(r)));
    end
  end

  assign req0_ready = w_ready[0];
  assign req1_ready = w_ready[1];
  assign RUWr       = r_ru_wr;
  assign RUrd       = r_ru_rd;
  assign RUDatawr   = r_ru_data;
  assign pending    = w_pending;

endmodule

// File: tb/tb_ru_write_arbiter.sv
// Bench for ru_write_arbiter: directed stimulus, expected writes queued in
// issue order and popped by an independent write-port monitor.
module tb_ru_write_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        CLK;
  logic        RST;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [4:0]  RUrd;
  logic [31:0] RUDatawr;
  logic        RUWr;
  logic [31:0] pending;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  logic a0, a1, rdy0, rdy1;

  ru_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
    .RUrd(RUrd), .RUDatawr(RUDatawr), .RUWr(RUWr), .pending(pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // One clock: drive at negedge, sample readiness, return just after posedge.
  task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       output logic acc0, output logic acc1,
                       output logic ready0, output logic ready1);
    @(negedge CLK);
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    #1;
    ready0 = req0_ready;
    ready1 = req1_ready;
    acc0   = v0 & req0_ready;
    acc1   = v1 & req1_ready;
    @(posedge CLK);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic idle();
    logic x0, x1, x2, x3;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, x0, x1, x2, x3);
  endtask

  // Write-port monitor: every RUWr must match the next queued write.
  always @(negedge CLK) begin
    if (RUWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write", RUrd, RUDatawr);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_rd", 32'(RUrd), 32'(mon_e.rd));
        chk("wr_data", RUDatawr, mon_e.data);
      end
    end
  end

  initial begin
    logic [4:0] c_rd  [6];
    logic       c_a0  [6];
    logic       c_r1  [6];
    c_rd = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5};
    c_a0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    c_r1 = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    RST = 1'b1;
    req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
    req1_valid = 1'b0; req1_rd = '0; req1_data = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_ruwr", 32'(RUWr), 32'd0);
    chk("rst_rurd", 32'(RUrd), 32'd0);
    chk("rst_data", RUDatawr, 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd1);
    chk("rst_ready1", 32'(req1_ready), 32'd1);

    // Single write with pending tracking
    push_exp(5'd5, 32'hDEADBEEF);
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a0, a1, rdy0, rdy1);
    chk("single_acc", 32'(a0), 32'd1);
    chk("single_pend_n", pending, 32'h0000_0020);
    chk("single_ruwr_n", 32'(RUWr), 32'd0);
    idle();
    chk("single_ruwr_n1", 32'(RUWr), 32'd1);
    chk("single_pend_n1", pending, 32'h0000_0020);
    idle();
    chk("single_pend_n2", pending, 32'd0);
    chk("single_ruwr_n2", 32'(RUWr), 32'd0);

    // Contention: req1 rd=9 starves for 3 arbitrations, then is forced
    push_exp(5'd1, 32'hA000_0001);
    push_exp(5'd2, 32'hA000_0002);
    push_exp(5'd3, 32'hA000_0003);
    push_exp(5'd9, 32'hB9B9_0009);
    push_exp(5'd4, 32'hA000_0004);
    push_exp(5'd5, 32'hA000_0005);
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, c_rd[s], 32'hA000_0000 + 32'(c_rd[s]),
            (s == 0), 5'd9, 32'hB9B9_0009, a0, a1, rdy0, rdy1);
      chk($sformatf("cont_acc0_%0d", s), 32'(a0), 32'(c_a0[s]));
      chk($sformatf("cont_rdy1_%0d", s), 32'(rdy1), 32'(c_r1[s]));
    end
    repeat (3) idle();
    chk("cont_drained", pending, 32'd0);

    // rd==0 handshake is accepted but never written
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_1234, a0, a1, rdy0, rdy1);
    chk("x0_acc1", 32'(a1), 32'd1);
    chk("x0_pending", pending, 32'd0);
    idle();
    chk("x0_ruwr1", 32'(RUWr), 32'd0);
    chk("x0_ready1", 32'(req1_ready), 32'd1);
    idle();
    chk("x0_ruwr2", 32'(RUWr), 32'd0);

    // Back-to-back req0 writes, one per cycle
    push_exp(5'd2, 32'hC000_0002);
    push_exp(5'd3, 32'hC000_0003);
    push_exp(5'd4, 32'hC000_0004);
    drive(1'b1, 5'd2, 32'hC000_0002, 1'b0, 5'd0, 32'd0, a0, a1, rdy0, rdy1);
    chk("b2b_acc_2", 32'(a0), 32'd1);
    chk("b2b_ruwr_0", 32'(RUWr), 32'd0);
    drive(1'b1, 5'd3, 32'hC000_0003, 1'b0, 5'd0, 32'd0, a0, a1, rdy0, rdy1);
    chk("b2b_acc_3", 32'(a0), 32'd1);
    chk("b2b_ruwr_1", 32'(RUWr), 32'd1);
    chk("b2b_rurd_1", 32'(RUrd), 32'd2);
    drive(1'b1, 5'd4, 32'hC000_0004, 1'b0, 5'd0, 32'd0, a0, a1, rdy0, rdy1);
    chk("b2b_acc_4", 32'(a0), 32'd1);
    chk("b2b_ruwr_2", 32'(RUWr), 32'd1);
    chk("b2b_rurd_2", 32'(RUrd), 32'd3);
    idle();
    chk("b2b_ruwr_3", 32'(RUWr), 32'd1);
    chk("b2b_rurd_3", 32'(RUrd), 32'd4);
    idle();
    chk("b2b_ruwr_4", 32'(RUWr), 32'd0);
    chk("b2b_rurd_hold", 32'(RUrd), 32'd4);

    // Reset mid-operation discards held entries and the in-flight write
    push_exp(5'd7, 32'hD000_0007);
    drive(1'b1, 5'd7, 32'hD000_0007, 1'b1, 5'd8, 32'hD000_0008, a0, a1, rdy0, rdy1);
    chk("mid_acc0", 32'(a0), 32'd1);
    chk("mid_acc1", 32'(a1), 32'd1);
    drive(1'b1, 5'd10, 32'hD000_000A, 1'b0, 5'd0, 32'd0, a0, a1, rdy0, rdy1);
    chk("mid_acc0b", 32'(a0), 32'd1);
    chk("mid_pending", pending, 32'h0000_0580);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rst_ruwr", 32'(RUWr), 32'd0);
    chk("mid_rst_pending", pending, 32'd0);
    chk("mid_rst_ready0", 32'(req0_ready), 32'd1);
    chk("mid_rst_ready1", 32'(req1_ready), 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    repeat (6) idle();
    chk("mid_pending_after", pending, 32'd0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
